// File: rtl/oht_map256_pkg.sv
// Shared definitions for the 256-entry occupancy map: sizes, flush
// sequencing constants, FSM state encoding and the index type.
package oht_pkg;

    localparam int N              = 256;
    localparam int L2N            = 8;
    localparam int CNT_W          = L2N + 1;
    localparam int FLUSH_QUARTERS = 4;
    localparam int QTR_W          = 2;
    localparam int QTR_BITS       = N / FLUSH_QUARTERS;

    typedef logic [L2N-1:0] idx_t;

    typedef enum logic {
        IDLE  = 1'b0,
        FLUSH = 1'b1
    } state_t;

endpackage

// File: rtl/oht_map256_if.sv
// Request/status bundle of the occupancy map. The map side uses the slave
// modport, the requester uses the master modport.
interface oht_map256_if;
    import oht_pkg::*;

    logic             i_set_vld;
    idx_t             i_set_idx;
    logic             o_set_rdy;
    logic             i_clr_vld;
    idx_t             i_clr_idx;
    logic             i_flush;
    logic [N-1:0]     o_map;
    logic [CNT_W-1:0] o_cnt;
    logic             o_empty;
    logic             o_full;
    logic             o_busy;
    logic             o_err_dup;

    modport slave (
        input  i_set_vld, i_set_idx, i_clr_vld, i_clr_idx, i_flush,
        output o_set_rdy, o_map, o_cnt, o_empty, o_full, o_busy, o_err_dup
    );

    modport master (
        output i_set_vld, i_set_idx, i_clr_vld, i_clr_idx, i_flush,
        input  o_set_rdy, o_map, o_cnt, o_empty, o_full, o_busy, o_err_dup
    );

endinterface

// File: rtl/oht_map256_dec256.sv
// dec256: combinational 8-to-256 binary to one-hot decoder.
module dec256
    import oht_pkg::*;
(
    input  idx_t         i_idx,
    output logic [N-1:0] o_onehot
);

    assign o_onehot = {{(N-1){1'b0}}, 1'b1} << i_idx;

endmodule

// File: rtl/oht_map256.sv
// oht_map256: 256-bit occupancy bitmap with set/clear requests, population
// count, duplicate-set detection and a 4-cycle quarter-by-quarter flush.
// Optional macro OHT_MAP_REG_OUT_EN adds one output register stage on
// map/cnt/empty/full; set_rdy, busy and err_dup keep their timing.
module oht_map256
    import oht_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    oht_map256_if.slave bus
);

    state_t           r_state, w_state_next;
    logic [QTR_W-1:0] r_q, w_q_next;
    logic [N-1:0]     r_map, w_map_next;
    logic [CNT_W-1:0] r_cnt, w_cnt_next;
    logic             r_err_dup, w_err_dup_next;

    logic [N-1:0]     w_set_oh, w_clr_oh;
    logic             w_idle, w_set_do, w_clr_do, w_same;
    logic             w_set_was, w_clr_was, w_s, w_c, w_dup;

    dec256 u_dec_set (.i_idx(bus.i_set_idx), .o_onehot(w_set_oh));
    dec256 u_dec_clr (.i_idx(bus.i_clr_idx), .o_onehot(w_clr_oh));

    // A flush in IDLE pre-empts any set/clear presented on the same cycle.
    assign w_idle    = (r_state == IDLE);
    assign w_set_do  = w_idle & bus.i_set_vld & ~bus.i_flush;
    assign w_clr_do  = w_idle & bus.i_clr_vld & ~bus.i_flush;
    assign w_same    = (bus.i_set_idx == bus.i_clr_idx);
    assign w_set_was = r_map[bus.i_set_idx];
    assign w_clr_was = r_map[bus.i_clr_idx];

    // Same-index set+clear: clear first, set wins, so only the set matters.
    assign w_s   = w_set_do & ~w_set_was;
    assign w_c   = w_clr_do & w_clr_was & ~(w_set_do & w_same);
    assign w_dup = w_set_do & w_set_was & ~(w_clr_do & w_same);

    // Next-state, next-map and next-count decision for both FSM states.
    always_comb begin
        // NOTE: every signal gets a default first so no path can infer a latch.
        w_state_next   = r_state;
        w_q_next       = r_q;
        w_map_next     = r_map;
        w_cnt_next     = r_cnt;
        w_err_dup_next = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.i_flush) begin
                    w_state_next = FLUSH;
                    w_q_next     = '0;
                end else begin
                    w_map_next     = (r_map & ~(w_clr_oh & {N{w_clr_do}}))
                                   | (w_set_oh & {N{w_set_do}});
                    w_cnt_next     = r_cnt + CNT_W'(w_s) - CNT_W'(w_c);
                    w_err_dup_next = w_dup;
                end
            end
            FLUSH: begin
                for (int k = 0; k < FLUSH_QUARTERS; k++) begin
                    if (r_q == QTR_W'(k)) begin
                        w_map_next[k*QTR_BITS +: QTR_BITS] = '0;
                    end
                end
                if (r_q == QTR_W'(FLUSH_QUARTERS - 1)) begin
                    w_state_next = IDLE;
                    w_q_next     = '0;
                    w_cnt_next   = '0;
                end else begin
                    w_q_next = r_q + 1'b1;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    // State registers; reset wins over everything, including a flush in flight.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            r_state   <= IDLE;
            r_q       <= '0;
            r_map     <= '0;
            r_cnt     <= '0;
            r_err_dup <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_q       <= w_q_next;
            r_map     <= w_map_next;
            r_cnt     <= w_cnt_next;
            r_err_dup <= w_err_dup_next;
        end
    end

    assign bus.o_set_rdy = w_idle;
    assign bus.o_busy    = (r_state == FLUSH);
    assign bus.o_err_dup = r_err_dup;

`ifdef OHT_MAP_REG_OUT_EN
    logic [N-1:0]     r_map_o;
    logic [CNT_W-1:0] r_cnt_o;
    logic             r_empty_o, r_full_o;

    // Extra output stage: the visible map/count lag the internal state by one cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_map_o   <= '0;
            r_cnt_o   <= '0;
            r_empty_o <= 1'b1;
            r_full_o  <= 1'b0;
        end else begin
            r_map_o   <= r_map;
            r_cnt_o   <= r_cnt;
            r_empty_o <= (r_cnt == '0);
            r_full_o  <= (r_cnt == CNT_W'(N));
        end
    end

    assign bus.o_map   = r_map_o;
    assign bus.o_cnt   = r_cnt_o;
    assign bus.o_empty = r_empty_o;
    assign bus.o_full  = r_full_o;
`else
    assign bus.o_map   = r_map;
    assign bus.o_cnt   = r_cnt;
    assign bus.o_empty = (r_cnt == '0);
    assign bus.o_full  = (r_cnt == CNT_W'(N));
`endif

endmodule

// File: tb/tb_oht_map256.sv
// tb_oht_map256: directed scenarios against a behavioural bitmap model,
// with a per-cycle compare process plus literal spot checks.
// Honours OHT_MAP_REG_OUT_EN to expect the extra output latency.
module tb_oht_map256;
    import oht_pkg::*;

`ifdef OHT_MAP_REG_OUT_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    oht_map256_if bus();

    oht_map256 dut (.clk(clk), .rst(rst), .bus(bus.slave));

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Behavioural model: a plain bit array, a flush countdown and popcount.
    logic [255:0] m_map  = '0;
    int           m_cnt  = 0;
    int           m_left = 0;
    bit           m_err  = 1'b0;
    bit           m_live = 1'b0;
    logic [255:0] exp_map = '0;
    int           exp_cnt = 0;

    task automatic model_step();
        logic [255:0] pm;
        int           pc;
        int           quarter;
        pm = rst ? '0 : m_map;
        pc = rst ? 0 : m_cnt;
        if (rst) begin
            m_map  = '0;
            m_cnt  = 0;
            m_left = 0;
            m_err  = 1'b0;
            m_live = 1'b1;
        end else if (m_left > 0) begin
            quarter = 4 - m_left;
            m_map[quarter*64 +: 64] = '0;
            m_left--;
            if (m_left == 0) m_cnt = 0;
            m_err = 1'b0;
        end else if (bus.i_flush) begin
            m_left = 4;
            m_err  = 1'b0;
        end else begin
            m_err = bus.i_set_vld && m_map[bus.i_set_idx]
                    && !(bus.i_clr_vld && bus.i_clr_idx == bus.i_set_idx);
            if (bus.i_clr_vld) m_map[bus.i_clr_idx] = 1'b0;
            if (bus.i_set_vld) m_map[bus.i_set_idx] = 1'b1;
            m_cnt = $countones(m_map);
        end
        if (LAT == 2) begin
            exp_map = pm;
            exp_cnt = pc;
        end else begin
            exp_map = m_map;
            exp_cnt = m_cnt;
        end
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        if (m_live) begin
            check("cmp_map",     bus.o_map,                exp_map);
            check("cmp_cnt",     256'(bus.o_cnt),          256'(exp_cnt));
            check("cmp_empty",   256'(bus.o_empty),        256'(exp_cnt == 0));
            check("cmp_full",    256'(bus.o_full),         256'(exp_cnt == 256));
            check("cmp_busy",    256'(bus.o_busy),         256'(m_left > 0));
            check("cmp_set_rdy", 256'(bus.o_set_rdy),      256'(m_left == 0));
            check("cmp_err_dup", 256'(bus.o_err_dup),      256'(m_err));
        end
    end

    task automatic cyc(input bit sv, input int si, input bit cv, input int ci, input bit fl);
        bus.i_set_vld = sv;
        bus.i_set_idx = 8'(si);
        bus.i_clr_vld = cv;
        bus.i_clr_idx = 8'(ci);
        bus.i_flush   = fl;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        check("rst_map",     bus.o_map,           256'(0));
        check("rst_cnt",     256'(bus.o_cnt),     256'(0));
        check("rst_empty",   256'(bus.o_empty),   256'(1));
        check("rst_full",    256'(bus.o_full),    256'(0));
        check("rst_busy",    256'(bus.o_busy),    256'(0));
        check("rst_err_dup", 256'(bus.o_err_dup), 256'(0));
        check("rst_set_rdy", 256'(bus.o_set_rdy), 256'(1));
    endtask

    logic [255:0] lit;
    logic [255:0] ones;

    initial begin
        ones = '1;
        bus.i_set_vld = 1'b0;
        bus.i_set_idx = '0;
        bus.i_clr_vld = 1'b0;
        bus.i_clr_idx = '0;
        bus.i_flush   = 1'b0;

        // Scenario 1: set 5, 200, 255.
        do_reset();
        cyc(1, 5, 0, 0, 0);
        cyc(1, 200, 0, 0, 0);
        cyc(1, 255, 0, 0, 0);
        idle(2);
        lit = '0;
        lit[5] = 1'b1;
        lit[200] = 1'b1;
        lit[255] = 1'b1;
        check("s1_map",   bus.o_map,         lit);
        check("s1_cnt",   256'(bus.o_cnt),   256'(3));
        check("s1_empty", 256'(bus.o_empty), 256'(0));

        // Scenario 2: duplicate set of 7.
        do_reset();
        cyc(1, 7, 0, 0, 0);
        cyc(1, 7, 0, 0, 0);
        check("s2_err_pulse", 256'(bus.o_err_dup), 256'(1));
        idle(1);
        check("s2_err_drop",  256'(bus.o_err_dup), 256'(0));
        idle(1);
        check("s2_cnt",       256'(bus.o_cnt),     256'(1));

        // Scenario 3: same-index and different-index set+clear.
        do_reset();
        cyc(1, 9, 0, 0, 0);
        idle(1);
        cyc(1, 9, 1, 9, 0);
        check("s3_same_no_err", 256'(bus.o_err_dup), 256'(0));
        idle(2);
        check("s3_same_map", bus.o_map,       256'(1) << 9);
        check("s3_same_cnt", 256'(bus.o_cnt), 256'(1));
        cyc(1, 10, 1, 9, 0);
        idle(2);
        check("s3_diff_map", bus.o_map,       256'(1) << 10);
        check("s3_diff_cnt", 256'(bus.o_cnt), 256'(1));

        // Scenario 4: fill, duplicate when full, flush in quarters.
        do_reset();
        for (int i = 0; i < 256; i++) cyc(1, i, 0, 0, 0);
        idle(2);
        check("s4_full", 256'(bus.o_full), 256'(1));
        check("s4_cnt",  256'(bus.o_cnt),  256'(256));
        cyc(1, 0, 0, 0, 0);
        check("s4_full_dup", 256'(bus.o_err_dup), 256'(1));
        idle(1);
        cyc(0, 0, 0, 0, 1);
        check("s4_busy_enter", 256'(bus.o_busy),    256'(1));
        check("s4_rdy_enter",  256'(bus.o_set_rdy), 256'(0));
        for (int k = 0; k < 4; k++) begin
            cyc(1, k, 1, 200 + k, 1);
            check("s4_fl_busy", 256'(bus.o_busy),    256'(k < 3));
            check("s4_fl_rdy",  256'(bus.o_set_rdy), 256'(k == 3));
            check("s4_fl_map",  bus.o_map,           ones << (64 * (k + 2 - LAT)));
            check("s4_fl_cnt",  256'(bus.o_cnt),     256'((k == 3 && LAT == 1) ? 0 : 256));
        end
        idle(2);
        check("s4_post_map",   bus.o_map,         256'(0));
        check("s4_post_cnt",   256'(bus.o_cnt),   256'(0));
        check("s4_post_empty", 256'(bus.o_empty), 256'(1));

        // Scenario 5: flush beats a coincident set; reset aborts a flush.
        do_reset();
        cyc(1, 3, 0, 0, 1);
        check("s5_busy", 256'(bus.o_busy), 256'(1));
        idle(5);
        check("s5_map", bus.o_map,       256'(0));
        check("s5_cnt", 256'(bus.o_cnt), 256'(0));
        cyc(1, 100, 0, 0, 0);
        idle(2);
        cyc(0, 0, 0, 0, 1);
        idle(1);
        do_reset();
        idle(2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
